// File: rtl/btle_pkg.sv
// Shared BLE advertising constants, scan-controller state encoding and small helpers.
// Imported by the scan controller and anything that needs the advertising defaults.
package btle_pkg;

    localparam logic [31:0] ADV_ACCESS_ADDRESS = 32'h8E89BED6;
    localparam logic [23:0] ADV_CRC_INIT       = 24'h555555;
    localparam logic [5:0]  ADV_CH_FIRST       = 6'd37;
    localparam logic [5:0]  ADV_CH_LAST        = 6'd39;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TUNE,
        ST_LISTEN,
        ST_RECEIVE,
        ST_HDR,
        ST_FETCH,
        ST_SEND,
        ST_HOP
    } scan_state_t;

    function automatic logic [5:0] next_adv_channel(input logic [5:0] ch);
        return (ch >= ADV_CH_LAST) ? ADV_CH_FIRST : ch + 6'd1;
    endfunction

    // Last octet address of a PDU: header(2) + payload, clamped to the 64-octet RAM.
    function automatic logic [5:0] pdu_last_addr(input logic [6:0] len);
        logic [7:0] n;
        n = {1'b0, len} + 8'd2;
        return (n >= 8'd64) ? 6'd63 : 6'(n - 8'd1);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

endpackage

// File: rtl/btle_rx_scan_ctrl_if.sv
// Host byte stream of the scan controller: ready/valid octets with an end-of-packet marker.
// The controller drives the master side, the host consumer the slave side.
interface btle_rx_scan_ctrl_if;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/btle_rx_scan_ctrl.sv
// BLE advertising-channel scan controller: hops 37/38/39, retunes btle_rx and streams decoded PDUs.
// Latency: hit -> RECEIVE 1 cycle, decode_end -> header beat 1 cycle, one octet per 2 cycles.
// Backpressure: beats held stable while m_ready=0; receiver samples gated during the whole readout.
module btle_rx_scan_ctrl
    import btle_pkg::*;
#(
    parameter int DWELL_WIDTH     = 20,
    parameter int MAX_PKT_SAMPLES = 8448
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [DWELL_WIDTH-1:0] dwell_samples,
    input  logic                   drop_bad_crc,
    input  logic                   iq_valid,
    output logic                   rx_iq_valid,
    output logic                   rx_rst,
    output logic [5:0]             channel_number,
    output logic [31:0]            unique_bit_sequence,
    output logic [23:0]            crc_state_init_bit,
    input  logic                   hit_flag,
    input  logic                   decode_end,
    input  logic                   crc_ok,
    input  logic [6:0]             payload_length,
    output logic [5:0]             pdu_octet_mem_addr,
    input  logic [7:0]             pdu_octet_mem_data,
    btle_rx_scan_ctrl_if.master    host,
    output logic [15:0]            pkt_count,
    output logic [15:0]            drop_count,
    output logic                   busy
);

    localparam int TO_WIDTH = $clog2(MAX_PKT_SAMPLES + 1);

    scan_state_t            state;
    logic                   gate;
    logic                   crc_ok_q;
    logic [5:0]             last_addr;
    logic [DWELL_WIDTH-1:0] dwell_cnt;
    logic [TO_WIDTH-1:0]    timeout_cnt;

    // Expiry includes the sample arriving this cycle, so exactly dwell_samples reach the receiver.
    logic [DWELL_WIDTH-1:0] dwell_nxt;
    logic [TO_WIDTH-1:0]    timeout_nxt;
    logic                   dwell_expired;
    logic                   timeout_expired;

    assign dwell_nxt       = dwell_cnt + DWELL_WIDTH'(iq_valid);
    assign timeout_nxt     = timeout_cnt + TO_WIDTH'(iq_valid);
    assign dwell_expired   = (dwell_samples != '0) && (dwell_nxt == dwell_samples);
    assign timeout_expired = (timeout_nxt == TO_WIDTH'(MAX_PKT_SAMPLES));

    assign rx_iq_valid         = iq_valid & ~gate;
    assign unique_bit_sequence = ADV_ACCESS_ADDRESS;
    assign crc_state_init_bit  = ADV_CRC_INIT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= ST_IDLE;
            rx_rst             <= 1'b1;
            gate               <= 1'b1;
            busy               <= 1'b0;
            channel_number     <= ADV_CH_FIRST;
            dwell_cnt          <= '0;
            timeout_cnt        <= '0;
            crc_ok_q           <= 1'b0;
            last_addr          <= '0;
            pdu_octet_mem_addr <= '0;
            host.m_data        <= '0;
            host.m_valid       <= 1'b0;
            host.m_last        <= 1'b0;
            pkt_count          <= '0;
            drop_count         <= '0;
        end else begin
            // Defaults describe every busy, gated, non-resetting state; states override below.
            rx_rst <= 1'b0;
            gate   <= 1'b1;
            busy   <= 1'b1;

            case (state)
                ST_IDLE: begin
                    rx_rst         <= 1'b1;
                    busy           <= enable;
                    channel_number <= ADV_CH_FIRST;
                    dwell_cnt      <= '0;
                    if (enable) state <= ST_TUNE;
                end

                ST_TUNE: begin
                    gate  <= 1'b0;
                    state <= ST_LISTEN;
                end

                ST_LISTEN: begin
                    gate      <= 1'b0;
                    dwell_cnt <= dwell_nxt;
                    if (hit_flag) begin
                        timeout_cnt <= '0;
                        state       <= ST_RECEIVE;
                    end else if (dwell_expired) begin
                        gate  <= 1'b1;
                        state <= ST_HOP;
                    end else if (!enable) begin
                        gate           <= 1'b1;
                        rx_rst         <= 1'b1;
                        busy           <= 1'b0;
                        channel_number <= ADV_CH_FIRST;
                        dwell_cnt      <= '0;
                        state          <= ST_IDLE;
                    end
                end

                ST_RECEIVE: begin
                    gate        <= 1'b0;
                    timeout_cnt <= timeout_nxt;
                    if (decode_end) begin
                        gate         <= 1'b1;
                        crc_ok_q     <= crc_ok;
                        last_addr    <= pdu_last_addr(payload_length);
                        host.m_data  <= {crc_ok, 1'b0, channel_number};
                        host.m_last  <= ~crc_ok;
                        // A suppressed bad-CRC packet enters HDR with no beat on offer.
                        host.m_valid <= crc_ok | ~drop_bad_crc;
                        state        <= ST_HDR;
                    end else if (timeout_expired) begin
                        gate       <= 1'b1;
                        drop_count <= sat_inc16(drop_count);
                        state      <= ST_HOP;
                    end
                end

                ST_HDR: begin
                    if (!host.m_valid || (host.m_ready && !crc_ok_q)) begin
                        host.m_valid <= 1'b0;
                        host.m_last  <= 1'b0;
                        drop_count   <= sat_inc16(drop_count);
                        rx_rst       <= 1'b1;
                        if (enable) begin
                            state <= ST_TUNE;
                        end else begin
                            busy           <= 1'b0;
                            channel_number <= ADV_CH_FIRST;
                            dwell_cnt      <= '0;
                            state          <= ST_IDLE;
                        end
                    end else if (host.m_ready) begin
                        host.m_valid       <= 1'b0;
                        pdu_octet_mem_addr <= '0;
                        state              <= ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    host.m_data  <= pdu_octet_mem_data;
                    host.m_last  <= (pdu_octet_mem_addr == last_addr);
                    host.m_valid <= 1'b1;
                    state        <= ST_SEND;
                end

                ST_SEND: begin
                    if (host.m_ready) begin
                        host.m_valid <= 1'b0;
                        host.m_last  <= 1'b0;
                        if (host.m_last) begin
                            pkt_count <= sat_inc16(pkt_count);
                            rx_rst    <= 1'b1;
                            if (enable) begin
                                state <= ST_TUNE;
                            end else begin
                                busy           <= 1'b0;
                                channel_number <= ADV_CH_FIRST;
                                dwell_cnt      <= '0;
                                state          <= ST_IDLE;
                            end
                        end else begin
                            pdu_octet_mem_addr <= pdu_octet_mem_addr + 6'd1;
                            state              <= ST_FETCH;
                        end
                    end
                end

                ST_HOP: begin
                    dwell_cnt <= '0;
                    rx_rst    <= 1'b1;
                    if (enable) begin
                        channel_number <= next_adv_channel(channel_number);
                        state          <= ST_TUNE;
                    end else begin
                        busy           <= 1'b0;
                        channel_number <= ADV_CH_FIRST;
                        state          <= ST_IDLE;
                    end
                end

                default: begin
                    rx_rst <= 1'b1;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btle_rx_scan_ctrl.sv
// Directed bench for btle_rx_scan_ctrl: hops, packet readout, backpressure, drops, timeout, clamp, reset.
// Stimulus pushes expected host beats into a queue; a negedge monitor pops and compares them.
module tb_btle_rx_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [19:0] dwell_samples = '0;
    logic        drop_bad_crc = 1'b0;
    logic        iq_valid = 1'b1;
    logic        rx_iq_valid;
    logic        rx_rst;
    logic [5:0]  channel_number;
    logic [31:0] unique_bit_sequence;
    logic [23:0] crc_state_init_bit;
    logic        hit_flag = 1'b0;
    logic        decode_end = 1'b0;
    logic        crc_ok = 1'b0;
    logic [6:0]  payload_length = '0;
    logic [5:0]  pdu_octet_mem_addr;
    logic [7:0]  pdu_octet_mem_data;
    logic [15:0] pkt_count;
    logic [15:0] drop_count;
    logic        busy;

    btle_rx_scan_ctrl_if host_if ();

    btle_rx_scan_ctrl #(.DWELL_WIDTH(20), .MAX_PKT_SAMPLES(8448)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .enable              (enable),
        .dwell_samples       (dwell_samples),
        .drop_bad_crc        (drop_bad_crc),
        .iq_valid            (iq_valid),
        .rx_iq_valid         (rx_iq_valid),
        .rx_rst              (rx_rst),
        .channel_number      (channel_number),
        .unique_bit_sequence (unique_bit_sequence),
        .crc_state_init_bit  (crc_state_init_bit),
        .hit_flag            (hit_flag),
        .decode_end          (decode_end),
        .crc_ok              (crc_ok),
        .payload_length      (payload_length),
        .pdu_octet_mem_addr  (pdu_octet_mem_addr),
        .pdu_octet_mem_data  (pdu_octet_mem_data),
        .host                (host_if),
        .pkt_count           (pkt_count),
        .drop_count          (drop_count),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [64];
    assign pdu_octet_mem_data = mem[pdu_octet_mem_addr];

    int checks = 0;
    int errors = 0;
    logic [8:0] sb [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pops one expectation per handshake and checks stalled beats stay put.
    logic [8:0] held;
    bit         holding = 0;
    always @(negedge clk) begin
        if (rst) begin
            holding = 0;
        end else begin
            if (holding) begin
                check("stall_valid", 32'(host_if.m_valid), 32'd1);
                check("stall_beat", 32'({host_if.m_data, host_if.m_last}), 32'(held));
            end
            if (host_if.m_valid) begin
                check("gate_readout", 32'(rx_iq_valid), 32'd0);
                if (host_if.m_ready) begin
                    holding = 0;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat actual=%0h required=none",
                                 {host_if.m_data, host_if.m_last});
                    end else begin
                        check("beat", 32'({host_if.m_data, host_if.m_last}), 32'(sb.pop_front()));
                    end
                end else begin
                    holding = 1;
                    held    = {host_if.m_data, host_if.m_last};
                end
            end else begin
                holding = 0;
            end
        end
    end

    // Counts samples reaching the receiver until the next retune, then the retune pulse width.
    task automatic run_until_tune(output int samples, output int rst_w);
        int cyc;
        cyc = 0; samples = 0; rst_w = 0;
        while (rx_rst !== 1'b1 && cyc < 20000) begin
            if (rx_iq_valid) samples++;
            tick(1);
            cyc++;
        end
        while (rx_rst === 1'b1 && rst_w < 50) begin
            rst_w++;
            tick(1);
        end
    endtask

    task automatic do_packet(input logic crc, input logic [6:0] len, input logic dropbad,
                             input bit exp_beat, input int stall_at, input logic [5:0] ch);
        int n, cyc;
        n = (int'(len) + 2 > 64) ? 64 : int'(len) + 2;
        if (exp_beat) begin
            sb.push_back({crc, 1'b0, ch, ~crc});
            if (crc) for (int i = 0; i < n; i++) sb.push_back({mem[i], i == n - 1});
        end
        hit_flag = 1'b1; tick(1); hit_flag = 1'b0; tick(3);
        crc_ok = crc; payload_length = len; drop_bad_crc = dropbad;
        decode_end = 1'b1; tick(1); decode_end = 1'b0;
        check("hdr_latency", 32'(host_if.m_valid), 32'(exp_beat));
        cyc = 0;
        while (rx_iq_valid !== 1'b1 && cyc < 1000) begin
            host_if.m_ready = !(cyc >= stall_at && cyc < stall_at + 5);
            tick(1);
            cyc++;
        end
        host_if.m_ready = 1'b1;
        check("pkt_return_listen", 32'(cyc < 1000), 32'd1);
        check("pkt_channel", 32'(channel_number), 32'(ch));
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    int s, w, cyc0;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'(8'h40 + 3 * i);
        host_if.m_ready = 1'b1;
        tick(2);
        check("rst_rx_rst", 32'(rx_rst), 32'd1);
        check("rst_channel", 32'(channel_number), 32'd37);
        check("rst_m_valid", 32'(host_if.m_valid), 32'd0);
        check("rst_m_last", 32'(host_if.m_last), 32'd0);
        check("rst_m_data", 32'(host_if.m_data), 32'd0);
        check("rst_addr", 32'(pdu_octet_mem_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gate", 32'(rx_iq_valid), 32'd0);
        check("rst_counts", {pkt_count, drop_count}, 32'd0);
        check("aa_const", unique_bit_sequence, 32'h8E89BED6);
        check("crc_init_const", 32'(crc_state_init_bit), 32'h555555);
        rst = 1'b0;
        tick(1);

        // Hop 37 -> 38 -> 39 -> 37 -> 38 with 100 samples per channel
        dwell_samples = 20'd100;
        enable = 1'b1;
        cyc0 = 0;
        while (rx_rst === 1'b1 && cyc0 < 10) begin tick(1); cyc0++; end
        check("busy_scan", 32'(busy), 32'd1);
        run_until_tune(s, w);
        check("hop1_samples", s, 100); check("hop1_rst_w", w, 1);
        check("hop1_ch", 32'(channel_number), 32'd38);
        run_until_tune(s, w);
        check("hop2_samples", s, 100); check("hop2_rst_w", w, 1);
        check("hop2_ch", 32'(channel_number), 32'd39);
        run_until_tune(s, w);
        check("hop3_samples", s, 100); check("hop3_rst_w", w, 1);
        check("hop3_ch", 32'(channel_number), 32'd37);
        run_until_tune(s, w);
        check("hop4_ch", 32'(channel_number), 32'd38);
        dwell_samples = 20'd0;

        // Good packet, then the same with a 5-cycle stall mid-packet
        do_packet(1'b1, 7'd6, 1'b0, 1'b1, 1000, 6'd38);
        check("good_pkt_count", 32'(pkt_count), 32'd1);
        check("good_drop_count", 32'(drop_count), 32'd0);
        do_packet(1'b1, 7'd3, 1'b0, 1'b1, 4, 6'd38);
        check("bp_pkt_count", 32'(pkt_count), 32'd2);

        // Bad CRC suppressed entirely
        do_packet(1'b0, 7'd5, 1'b1, 1'b0, 1000, 6'd38);
        check("crcdrop_count", 32'(drop_count), 32'd1);
        check("crcdrop_pkt_count", 32'(pkt_count), 32'd2);

        // Receive timeout: 8448 samples then hop to 39
        hit_flag = 1'b1; tick(1); hit_flag = 1'b0;
        run_until_tune(s, w);
        check("to_samples", s, 8448); check("to_rst_w", w, 1);
        check("to_ch", 32'(channel_number), 32'd39);
        check("to_drop_count", 32'(drop_count), 32'd2);
        dwell_samples = 20'd100;
        run_until_tune(s, w);
        check("hop5_ch", 32'(channel_number), 32'd37);
        dwell_samples = 20'd0;

        // Bad CRC forwarded as a single last-marked header on 37
        do_packet(1'b0, 7'd5, 1'b0, 1'b1, 1000, 6'd37);
        check("crcfwd_drop_count", 32'(drop_count), 32'd3);

        // Length clamp: 100-octet payload reads exactly 64 octets
        do_packet(1'b1, 7'd100, 1'b0, 1'b1, 1000, 6'd37);
        check("clamp_pkt_count", 32'(pkt_count), 32'd3);

        // Async reset while a data beat is stalled in SEND
        host_if.m_ready = 1'b0;
        sb.push_back({8'hA5, 1'b0});
        hit_flag = 1'b1; tick(1); hit_flag = 1'b0; tick(2);
        crc_ok = 1'b1; payload_length = 7'd10;
        decode_end = 1'b1; tick(1); decode_end = 1'b0;
        host_if.m_ready = 1'b1; tick(1); host_if.m_ready = 1'b0;
        tick(2);
        check("pre_rst_send_valid", 32'(host_if.m_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_m_valid", 32'(host_if.m_valid), 32'd0);
        check("arst_m_last", 32'(host_if.m_last), 32'd0);
        check("arst_channel", 32'(channel_number), 32'd37);
        check("arst_rx_rst", 32'(rx_rst), 32'd1);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_counts", {pkt_count, drop_count}, 32'd0);
        check("arst_sb", 32'(sb.size()), 32'd0);
        host_if.m_ready = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
